// File: rtl/ab_input_debounce.sv
// ab_input_debounce: conditions two raw, asynchronous switch lines into
// clean synchronized levels (a, b) that feed the AND gate directly, plus
// one-cycle rise/fall event pulses per channel. The channels are identical
// and fully independent; each is an instance of ab_input_debounce_chan.

// One debounce channel: two-flop synchronizer, stability counter,
// accepted level and registered edge pulses.
module ab_input_debounce_chan #(
  parameter int DB_CYCLES = 4,
  parameter int CNT_W     = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  // Counter value at which the DB_CYCLES-th disagreeing sample is seen.
  // DB_CYCLES may equal 2^CNT_W, so the last count still fits in CNT_W bits.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  // Synchronizer stages; only s2_r is used by the debounce logic.
  logic             s1_r;
  logic             s2_r;

  // Accepted level, stability counter and pulse registers.
  logic             q_r;
  logic [CNT_W-1:0] cnt_r;
  logic             rise_r;
  logic             fall_r;

  // Next-state values from the debounce decision.
  logic             q_s;
  logic [CNT_W-1:0] cnt_s;
  logic             rise_s;
  logic             fall_s;
  logic             differs_s;
  logic             at_last_s;

  // Two-flop synchronizer bringing the asynchronous raw line into clk.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_r <= 1'b0;
      s2_r <= 1'b0;
    end else begin
      s1_r <= raw;
      s2_r <= s1_r;
    end
  end

  // Debounce decision: count consecutive disagreeing samples, accept on the
  // DB_CYCLES-th one, and restart the count on any agreement with q.
  always_comb begin
    q_s       = q_r;
    cnt_s     = cnt_r;
    rise_s    = 1'b0;
    fall_s    = 1'b0;
    differs_s = (s2_r != q_r);
    at_last_s = (cnt_r == CNT_LAST);
    if (!differs_s) begin
      cnt_s = CNT_ZERO;
    end else if (at_last_s) begin
      q_s    = s2_r;
      cnt_s  = CNT_ZERO;
      rise_s = s2_r;
      fall_s = ~s2_r;
    end else begin
      cnt_s = cnt_r + CNT_ONE;
    end
  end

  // Debounce state and pulse registers; reset overrides any pending accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_r    <= 1'b0;
      cnt_r  <= CNT_ZERO;
      rise_r <= 1'b0;
      fall_r <= 1'b0;
    end else begin
      q_r    <= q_s;
      cnt_r  <= cnt_s;
      rise_r <= rise_s;
      fall_r <= fall_s;
    end
  end

  assign level = q_r;
  assign rise  = rise_r;
  assign fall  = fall_r;

endmodule

// Top level: two independent debounce channels, A and B.
module ab_input_debounce #(
  parameter int DB_CYCLES = 4,
  parameter int CNT_W     = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic a_raw,
  input  logic b_raw,
  output logic a,
  output logic b,
  output logic a_rise,
  output logic a_fall,
  output logic b_rise,
  output logic b_fall
);

  ab_input_debounce_chan #(
    .DB_CYCLES (DB_CYCLES),
    .CNT_W     (CNT_W)
  ) u_chan_a (
    .clk   (clk),
    .rst   (rst),
    .raw   (a_raw),
    .level (a),
    .rise  (a_rise),
    .fall  (a_fall)
  );

  ab_input_debounce_chan #(
    .DB_CYCLES (DB_CYCLES),
    .CNT_W     (CNT_W)
  ) u_chan_b (
    .clk   (clk),
    .rst   (rst),
    .raw   (b_raw),
    .level (b),
    .rise  (b_rise),
    .fall  (b_fall)
  );

endmodule
